// File: rtl/result_stream_packer_if.sv
`default_nettype none
// Controller-side capture/frame signals and host-side stream signals of the packer.
interface result_stream_packer_if #(
   parameter int DEPTH = 8
);
   logic                   req;
   logic                   rd_wr;
   logic [1:0]             wr_index;
   logic [31:0]            write_data;
   logic [7:0]             set;
   logic                   set_done;
   logic [31:0]            host_data;
   logic                   host_valid;
   logic                   host_ready;
   logic                   host_last;
   logic [15:0]            frame_count;
   logic                   seq_err;
   logic                   overflow;
   logic [$clog2(DEPTH):0] entries;

   modport master (
      output req, rd_wr, wr_index, write_data, set, set_done, host_ready,
      input  host_data, host_valid, host_last, frame_count, seq_err, overflow, entries
   );

   modport slave (
      input  req, rd_wr, wr_index, write_data, set, set_done, host_ready,
      output host_data, host_valid, host_last, frame_count, seq_err, overflow, entries
   );
endinterface
`default_nettype wire

// File: rtl/result_stream_packer.sv
`default_nettype none
// Result stream packer: assembles three result words per set into a tagged record,
// queues records and frame markers, and streams them to the host as 32-bit words.
module result_stream_packer #(
   parameter int         DEPTH   = 8,
   parameter logic [7:0] HDR_TAG = 8'hA5
) (
   input  wire                   clk,
   input  wire                   rst_n,
   result_stream_packer_if.slave bus
);
   localparam int              c_AW      = $clog2(DEPTH);
   localparam logic [c_AW:0]   c_FULL    = (c_AW+1)'(DEPTH);
   localparam logic [c_AW:0]   c_CNT_ONE = (c_AW+1)'(1);
   localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

   typedef struct packed {
      logic        typ;
      logic [7:0]  set;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
   } entry_t;

   typedef enum logic [1:0] {EXP0 = 2'd0, EXP1 = 2'd1, EXP2 = 2'd2} asm_t;
   typedef enum logic [2:0] {IDLE = 3'd0, HDR = 3'd1, D0 = 3'd2, D1 = 3'd3, D2 = 3'd4} drn_t;

   function automatic logic [31:0] f_hdr(input logic typ, input logic [7:0] s);
      return {HDR_TAG, s, 7'b0, typ, 8'b0};
   endfunction

   asm_t            r_asm;
   logic [31:0]     r_w0;
   logic [31:0]     r_w1;
   logic [7:0]      r_set;
   logic            r_seq_err;
   logic            r_pend;
   logic [7:0]      r_pend_set;
   entry_t          r_mem [DEPTH];
   logic [c_AW-1:0] r_wp;
   logic [c_AW-1:0] r_rp;
   logic [c_AW:0]   r_cnt;
   logic            r_overflow;
   logic [15:0]     r_frame_cnt;
   drn_t            r_drn;
   logic            r_valid;
   logic            r_last;
   logic [31:0]     r_data;

   logic            w_cap;
   logic            w_data_push;
   logic            w_mark_req;
   logic [7:0]      w_mark_set;
   logic            w_push;
   logic            w_push_ok;
   logic            w_pop;
   logic            w_acc;
   logic            w_more;
   logic            w_next_typ;
   logic [7:0]      w_next_set;
   logic [c_AW-1:0] w_rp_nxt;
   entry_t          w_push_entry;
   entry_t          w_head;

   assign w_cap       = bus.req & bus.rd_wr;
   assign w_data_push = w_cap && (r_asm == EXP2) && (bus.wr_index == 2'd2);

   // Index 0 always (re)starts a record; any other out-of-order index abandons it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_asm     <= EXP0;
         r_w0      <= '0;
         r_w1      <= '0;
         r_set     <= '0;
         r_seq_err <= 1'b0;
      end else if (w_cap) begin
         if (bus.wr_index == 2'd0) begin
            r_w0  <= bus.write_data;
            r_set <= bus.set;
            r_asm <= EXP1;
            if (r_asm != EXP0) r_seq_err <= 1'b1;
         end else if ((r_asm == EXP1) && (bus.wr_index == 2'd1)) begin
            r_w1  <= bus.write_data;
            r_asm <= EXP2;
         end else if ((r_asm == EXP2) && (bus.wr_index == 2'd2)) begin
            r_asm <= EXP0;
         end else begin
            r_seq_err <= 1'b1;
            r_asm     <= EXP0;
         end
      end
   end

   // A marker colliding with a data push waits one cycle; repeats while waiting merge.
   assign w_mark_req = bus.set_done | r_pend;
   assign w_mark_set = r_pend ? r_pend_set : bus.set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend     <= 1'b0;
         r_pend_set <= '0;
      end else begin
         r_pend <= w_data_push & w_mark_req;
         if (w_data_push & ~r_pend) r_pend_set <= bus.set;
      end
   end

   assign w_push       = w_data_push | w_mark_req;
   assign w_push_entry = w_data_push ? {1'b0, r_set, r_w0, r_w1, bus.write_data}
                                     : {1'b1, w_mark_set, 96'b0};
   assign w_push_ok    = w_push & ((r_cnt != c_FULL) | w_pop);

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wp] <= w_push_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp        <= '0;
         r_rp        <= '0;
         r_cnt       <= '0;
         r_overflow  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         if (w_push_ok) r_wp <= r_wp + c_PTR_ONE;
         if (w_pop)     r_rp <= w_rp_nxt;
         if (w_push_ok && !w_pop)      r_cnt <= r_cnt + c_CNT_ONE;
         else if (!w_push_ok && w_pop) r_cnt <= r_cnt - c_CNT_ONE;
         if (w_push && !w_push_ok)      r_overflow  <= 1'b1;
         if (w_push_ok && !w_data_push) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign w_head   = r_mem[r_rp];
   assign w_acc    = r_valid & bus.host_ready;
   assign w_pop    = w_acc & (((r_drn == HDR) & w_head.typ) | (r_drn == D2));
   assign w_rp_nxt = r_rp + c_PTR_ONE;
   // With a single entry left, the follow-on header comes straight from this cycle's push.
   assign w_more     = (r_cnt > c_CNT_ONE) | w_push_ok;
   assign w_next_typ = (r_cnt > c_CNT_ONE) ? r_mem[w_rp_nxt].typ : w_push_entry.typ;
   assign w_next_set = (r_cnt > c_CNT_ONE) ? r_mem[w_rp_nxt].set : w_push_entry.set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drn   <= IDLE;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
      end else if (w_pop) begin
         if (w_more) begin
            r_drn   <= HDR;
            r_valid <= 1'b1;
            r_data  <= f_hdr(w_next_typ, w_next_set);
            r_last  <= w_next_typ;
         end else begin
            r_drn   <= IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
         end
      end else begin
         case (r_drn)
            IDLE: if (r_cnt != '0) begin
               r_drn   <= HDR;
               r_valid <= 1'b1;
               r_data  <= f_hdr(w_head.typ, w_head.set);
               r_last  <= w_head.typ;
            end
            HDR: if (w_acc) begin
               r_drn  <= D0;
               r_data <= w_head.w0;
               r_last <= 1'b0;
            end
            D0: if (w_acc) begin
               r_drn  <= D1;
               r_data <= w_head.w1;
            end
            D1: if (w_acc) begin
               r_drn  <= D2;
               r_data <= w_head.w2;
               r_last <= 1'b1;
            end
            D2: ;
            default: begin
               r_drn   <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.host_data   = r_data;
   assign bus.host_valid  = r_valid;
   assign bus.host_last   = r_last;
   assign bus.frame_count = r_frame_cnt;
   assign bus.seq_err     = r_seq_err;
   assign bus.overflow    = r_overflow;
   assign bus.entries     = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_result_stream_packer.sv
`default_nettype none
// Bench for result_stream_packer: directed vector table, multi-cycle corner sequences
// and a randomized run scored against a record-level reference model.
module tb_result_stream_packer;
   localparam int DEPTH = 8;
   localparam int NV    = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   result_stream_packer_if #(.DEPTH(DEPTH)) bus ();
   result_stream_packer #(.DEPTH(DEPTH), .HDR_TAG(8'hA5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } word_t;

   typedef struct {
      logic [7:0]  set;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      bit          done;
      logic [31:0] hdr;
      logic [31:0] mhdr;
      int          peak;
   } vec_t;

   word_t       expq [$];
   vec_t        vt [NV];
   int          exp_frames = 0;
   int          acc_cnt    = 0;
   bit          mdl_on     = 1'b0;
   bit          m_err      = 1'b0;
   logic [31:0] part [$];
   logic [7:0]  part_set;
   logic        stall_prev = 1'b0;
   logic [33:0] stall_word;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_word(input logic [31:0] d, input logic l);
      word_t w;
      w.data = d;
      w.last = l;
      expq.push_back(w);
   endtask

   task automatic exp_rec(input logic [7:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
      exp_word({8'hA5, s, 16'h0000}, 1'b0);
      exp_word(a, 1'b0);
      exp_word(b, 1'b0);
      exp_word(c, 1'b1);
   endtask

   task automatic exp_mark(input logic [7:0] s);
      exp_word({8'hA5, s, 8'h01, 8'h00}, 1'b1);
   endtask

   task automatic cap(input logic [1:0] idx, input logic [31:0] d, input logic [7:0] s,
                      input bit done);
      bus.req        = 1'b1;
      bus.rd_wr      = 1'b1;
      bus.wr_index   = idx;
      bus.write_data = d;
      bus.set        = s;
      bus.set_done   = done;
      tick();
      bus.req      = 1'b0;
      bus.rd_wr    = 1'b0;
      bus.set_done = 1'b0;
   endtask

   task automatic rec(input logic [7:0] s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input bit done);
      cap(2'd0, a, s, 1'b0);
      cap(2'd1, b, s, 1'b0);
      cap(2'd2, c, s, done);
   endtask

   task automatic drain(input int lim);
      int n = 0;
      while ((expq.size() != 0 || bus.host_valid) && n < lim) begin
         tick();
         n++;
      end
      total++;
      if (n >= lim) begin
         bad++;
         $display("FAIL drain_timeout: got %0d words pending expected 0", expq.size());
      end
   endtask

   function automatic logic [31:0] fw(input int r, input int k);
      return {8'(r), 8'(k), 16'hBEEF};
   endfunction

   // Scoreboard: every accepted word must be the next expected one; stalls must hold.
   always @(negedge clk) begin : mon
      word_t e;
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            chk("stall_hold", {bus.host_valid, bus.host_last, bus.host_data}, stall_word);
         if (bus.host_valid && bus.host_ready) begin
            acc_cnt++;
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_word: got %h expected none", bus.host_data);
            end else begin
               e = expq.pop_front();
               chk("stream_word", {bus.host_last, bus.host_data}, {e.last, e.data});
            end
         end
         stall_prev = bus.host_valid && !bus.host_ready;
         stall_word = {bus.host_valid, bus.host_last, bus.host_data};
      end
   end

   // Reference model: collects words in order per set; a complete triple becomes a record.
   always @(posedge clk) begin
      if (mdl_on && rst_n) begin
         if (bus.req && bus.rd_wr) begin
            if (bus.wr_index == part.size()) begin
               if (bus.wr_index == 2'd0) part_set = bus.set;
               part.push_back(bus.write_data);
               if (part.size() == 3) begin
                  exp_rec(part_set, part[0], part[1], part[2]);
                  part.delete();
               end
            end else if (bus.wr_index == 2'd0) begin
               m_err = 1'b1;
               part.delete();
               part.push_back(bus.write_data);
               part_set = bus.set;
            end else begin
               m_err = 1'b1;
               part.delete();
            end
         end
         if (bus.set_done) begin
            exp_mark(bus.set);
            exp_frames++;
         end
      end
   end

   initial begin
      bit last_idx2;
      bit last_done;
      vt[0] = '{set:8'd5,   w0:32'h11111111, w1:32'h22222222, w2:32'h33333333, done:1'b0,
                hdr:32'hA5050000, mhdr:32'h0, peak:1};
      vt[1] = '{set:8'd149, w0:32'hCAFEF00D, w1:32'h00000001, w2:32'h80000000, done:1'b1,
                hdr:32'hA5950000, mhdr:32'hA5950100, peak:2};
      vt[2] = '{set:8'd0,   w0:32'h00000000, w1:32'h00000000, w2:32'hFFFFFFFF, done:1'b0,
                hdr:32'hA5000000, mhdr:32'h0, peak:1};
      vt[3] = '{set:8'd255, w0:32'hDEADBEEF, w1:32'h12345678, w2:32'h9ABCDEF0, done:1'b1,
                hdr:32'hA5FF0000, mhdr:32'hA5FF0100, peak:2};
      vt[4] = '{set:8'h3C,  w0:32'h5A5A5A5A, w1:32'hA5A5A5A5, w2:32'h0F0F0F0F, done:1'b0,
                hdr:32'hA53C0000, mhdr:32'h0, peak:1};

      bus.req = 1'b0; bus.rd_wr = 1'b0; bus.wr_index = 2'd0; bus.write_data = '0;
      bus.set = '0; bus.set_done = 1'b0; bus.host_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_valid", bus.host_valid, 0);
      chk("rst_data", bus.host_data, 0);
      chk("rst_last", bus.host_last, 0);
      chk("rst_entries", bus.entries, 0);
      chk("rst_frames", bus.frame_count, 0);
      chk("rst_seq_err", bus.seq_err, 0);
      chk("rst_overflow", bus.overflow, 0);
      rst_n = 1'b1;
      tick();

      bus.host_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         exp_word(vt[i].hdr, 1'b0);
         exp_word(vt[i].w0, 1'b0);
         exp_word(vt[i].w1, 1'b0);
         exp_word(vt[i].w2, 1'b1);
         if (vt[i].done) begin
            exp_word(vt[i].mhdr, 1'b1);
            exp_frames++;
         end
         rec(vt[i].set, vt[i].w0, vt[i].w1, vt[i].w2, vt[i].done);
         chk("entry_visible", bus.entries, 1);
         chk("valid_early", bus.host_valid, 0);
         tick();
         chk("valid_latency", bus.host_valid, 1);
         chk("entries_peak", bus.entries, vt[i].peak);
         drain(50);
         chk("frame_count", bus.frame_count, exp_frames);
      end

      // Fill to capacity with the host stalled.
      bus.host_ready = 1'b0;
      for (int r = 1; r <= DEPTH; r++) begin
         exp_rec(8'(r), fw(r, 0), fw(r, 1), fw(r, 2));
         rec(8'(r), fw(r, 0), fw(r, 1), fw(r, 2), 1'b0);
      end
      tick();
      chk("full_entries", bus.entries, DEPTH);
      chk("full_no_ovf", bus.overflow, 0);

      // Pop on D2 coincides with a push into the full FIFO.
      exp_rec(8'd9, fw(9, 0), fw(9, 1), fw(9, 2));
      cap(2'd0, fw(9, 0), 8'd9, 1'b0);
      cap(2'd1, fw(9, 1), 8'd9, 1'b0);
      bus.host_ready = 1'b1;
      tick();
      tick();
      tick();
      chk("d2_data", bus.host_data, fw(1, 2));
      chk("d2_last", bus.host_last, 1);
      cap(2'd2, fw(9, 2), 8'd9, 1'b0);
      bus.host_ready = 1'b0;
      chk("swap_entries", bus.entries, DEPTH);
      chk("swap_no_ovf", bus.overflow, 0);

      // A record arriving at a full FIFO is dropped.
      rec(8'd10, fw(10, 0), fw(10, 1), fw(10, 2), 1'b0);
      tick();
      chk("ovf_entries", bus.entries, DEPTH);
      chk("ovf_flag", bus.overflow, 1);
      acc_cnt = 0;
      bus.host_ready = 1'b1;
      drain(200);
      chk("ovf_word_count", acc_cnt, 32);
      chk("ovf_sticky", bus.overflow, 1);

      // Out-of-order index: 0 then 2.
      chk("seq_clean", bus.seq_err, 0);
      cap(2'd0, 32'h0BAD0000, 8'd3, 1'b0);
      cap(2'd2, 32'h0BAD0002, 8'd3, 1'b0);
      tick();
      chk("seq_err_set", bus.seq_err, 1);
      chk("seq_no_push", bus.entries, 0);
      chk("seq_no_valid", bus.host_valid, 0);
      exp_rec(8'd4, 32'h40, 32'h41, 32'h42);
      rec(8'd4, 32'h40, 32'h41, 32'h42, 1'b0);
      drain(50);
      chk("seq_recover_entries", bus.entries, 0);

      // set_done with the index-2 write and again while the marker is pending.
      exp_rec(8'd7, 32'h70, 32'h71, 32'h72);
      exp_mark(8'd7);
      exp_frames++;
      rec(8'd7, 32'h70, 32'h71, 32'h72, 1'b1);
      bus.set_done = 1'b1;
      tick();
      bus.set_done = 1'b0;
      drain(50);
      chk("merge_frames", bus.frame_count, exp_frames);

      // Reset in the middle of D1.
      rec(8'h42, 32'hA0, 32'hA1, 32'hA2, 1'b0);
      exp_rec(8'h42, 32'hA0, 32'hA1, 32'hA2);
      tick();
      tick();
      tick();
      chk("d1_data", bus.host_data, 32'hA1);
      expq.delete();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.host_valid, 0);
      chk("mid_rst_entries", bus.entries, 0);
      chk("mid_rst_frames", bus.frame_count, 0);
      exp_frames = 0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", bus.host_valid, 0);
      exp_rec(8'h43, 32'hB0, 32'hB1, 32'hB2);
      rec(8'h43, 32'hB0, 32'hB1, 32'hB2, 1'b0);
      drain(50);

      // Randomized traffic against the reference model.
      m_err     = 1'b0;
      part.delete();
      mdl_on    = 1'b1;
      last_idx2 = 1'b0;
      last_done = 1'b0;
      for (int c = 0; c < 600; c++) begin
         bus.req        = 1'b0;
         bus.rd_wr      = 1'b0;
         bus.set_done   = 1'b0;
         bus.host_ready = ($urandom_range(0, 99) < 70);
         bus.set        = 8'($urandom_range(0, 255));
         if (bus.entries < DEPTH - 2) begin
            if ($urandom_range(0, 99) < 55) begin
               bus.req        = 1'b1;
               bus.rd_wr      = ($urandom_range(0, 9) != 0);
               bus.wr_index   = ($urandom_range(0, 99) < 85) ? 2'(part.size())
                                                             : 2'($urandom_range(0, 3));
               bus.write_data = $urandom;
            end
            if (!last_idx2 && !last_done && $urandom_range(0, 99) < 6) bus.set_done = 1'b1;
         end
         last_idx2 = bus.req && bus.rd_wr && (bus.wr_index == 2'd2);
         last_done = bus.set_done;
         tick();
      end
      bus.req      = 1'b0;
      bus.rd_wr    = 1'b0;
      bus.set_done = 1'b0;
      mdl_on       = 1'b0;
      bus.host_ready = 1'b1;
      drain(400);
      chk("rand_seq_err", bus.seq_err, m_err);
      chk("rand_frames", bus.frame_count, exp_frames);
      chk("rand_overflow", bus.overflow, 0);
      chk("rand_entries", bus.entries, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
